keypad_scanner: RTL and testbench

Parametrised, clocked matrix-keypad scanner for the ChargePhone front panel. It drives keypad rows one at a time, samples the columns, debounces per scan frame and emits exactly one single-cycle event per key press, with optional auto-repeat. For the default 4x4 pad it also decodes the key into the panel functions: digit, start, clear and enter. It replaces edge-triggered, strobe-based key decoding and sits between the keypad pins and the dial/charge control logic.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_scanner_if.sv | 15 +
 rtl/keypad_keymap.sv | 43 ++++
 rtl/keypad_scanner.sv | 233 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEB  = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_t;

    localparam logic [4:0] NUM_NONE = 5'd20;

    localparam int KEY_ZERO  = 9;
    localparam int KEY_START = 10;
    localparam int KEY_CLEAR = 11;
    localparam int KEY_ENTER = 12;

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key event bundle from the scanner to the dial/charge logic
interface keypad_scanner_if #(
    parameter int CW = 4
) ();
    logic          key_valid;
    logic [CW-1:0] key_code;
    logic          key_held;
    logic [4:0]    num;
    logic          start;
    logic          clear;
    logic          enter;

    modport master (output key_valid, key_code, key_held, num, start, clear, enter);
    modport slave  (input  key_valid, key_code, key_held, num, start, clear, enter);
endinterface

// File: rtl/keypad_keymap.sv
// rtl/keypad_keymap.sv - combinational key code to panel function decode
module keypad_keymap
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int CW   = 4
) (
    input  logic [CW-1:0] code,
    output logic [4:0]    num,
    output logic          start,
    output logic          clear,
    output logic          enter
);

    generate
        if (ROWS == 4 && COLS == 4) begin : g_map
            always_comb begin
                num   = NUM_NONE;
                start = 1'b0;
                clear = 1'b0;
                enter = 1'b0;
                if (code <= CW'(8)) begin
                    num = 5'(code) + 5'd1;
                end else if (code == CW'(KEY_ZERO)) begin
                    num = 5'd0;
                end
                start = (code == CW'(KEY_START));
                clear = (code == CW'(KEY_CLEAR));
                enter = (code == CW'(KEY_ENTER));
            end
        end else begin : g_none
            // Non-standard pad sizes have no panel meaning.
            logic unused_code;
            assign unused_code = ^code;
            assign num   = NUM_NONE;
            assign start = 1'b0;
            assign clear = 1'b0;
            assign enter = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-scanning matrix keypad scanner with frame debounce and auto-repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [ROWS-1:0] row_o,
    input  logic [COLS-1:0] col_i,
    keypad_scanner_if.master ev
);

    localparam int CW = $clog2(ROWS * COLS);
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int PW = 16;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_DEB  = ST_DEB;
    localparam logic [1:0] S_HELD = ST_HELD;
    localparam logic [1:0] S_REL  = ST_REL;

    logic [COLS-1:0] col_s1, col_s2;
    logic [DW-1:0]   div_cnt;
    logic [RW-1:0]   row_idx;
    logic            sample, frame_end;

    logic [1:0]      row_hits, acc_hits;
    logic [CW-1:0]   row_col, row_code, acc_code, fr_code;
    logic [2:0]      tot_hits;
    frame_t          fr;

    logic [1:0]      state;
    logic [3:0]      cnt, cnt_inc;
    logic [CW-1:0]   cand;
    logic [PW-1:0]   rep_cnt, rep_target;
    logic            rep_first, rep_due, rep_fire, accept, ev_fire;
    logic [CW-1:0]   ev_code;

    logic            key_valid_q, key_held_q, start_q, clear_q, enter_q;
    logic [CW-1:0]   key_code_q;
    logic [4:0]      num_q, map_num;
    logic            map_start, map_clear, map_enter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= col_i;
            col_s2 <= col_s1;
        end
    end

    assign sample    = (div_cnt == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (row_idx == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            row_idx <= '0;
        end else if (sample) begin
            div_cnt <= '0;
            row_idx <= frame_end ? '0 : row_idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        row_o          = '1;
        row_o[row_idx] = 1'b0;
    end

    // Hits saturate at two: beyond that only "more than one" matters.
    always_comb begin
        row_hits = 2'd0;
        row_col  = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_s2[c]) begin
                row_col = CW'(c);
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
            end
        end
    end

    assign row_code = CW'(row_idx) * CW'(COLS) + row_col;
    assign tot_hits = {1'b0, acc_hits} + {1'b0, row_hits};
    assign fr_code  = (acc_hits != 2'd0) ? acc_code : row_code;

    always_comb begin
        fr = FR_MULTI;
        if (tot_hits == 3'd0)      fr = FR_NONE;
        else if (tot_hits == 3'd1) fr = FR_SINGLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hits <= 2'd0;
            acc_code <= '0;
        end else if (sample) begin
            if (frame_end) begin
                acc_hits <= 2'd0;
                acc_code <= '0;
            end else begin
                acc_hits <= (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
                acc_code <= fr_code;
            end
        end
    end

    assign cnt_inc    = cnt + 4'd1;
    assign accept     = frame_end && (fr == FR_SINGLE) &&
                        (((state == S_IDLE) && (DEBOUNCE == 1)) ||
                         ((state == S_DEB) && (fr_code == cand) && (cnt_inc == 4'(DEBOUNCE))));
    assign rep_target = rep_first ? PW'(REPEAT_PER) : PW'(REPEAT_DLY);
    // A chord still advances the repeat schedule but never emits.
    assign rep_due    = (REPEAT_EN != 0) && frame_end && (state == S_HELD) &&
                        (fr != FR_NONE) && (rep_cnt + PW'(1) == rep_target);
    assign rep_fire   = rep_due && (fr == FR_SINGLE);
    assign ev_fire    = accept || rep_fire;
    assign ev_code    = accept ? fr_code : key_code_q;

    keypad_keymap #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) u_keymap (
        .code  (ev_code),
        .num   (map_num),
        .start (map_start),
        .clear (map_clear),
        .enter (map_enter)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            cand        <= '0;
            rep_cnt     <= '0;
            rep_first   <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            num_q       <= NUM_NONE;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            enter_q     <= 1'b0;
        end else begin
            key_valid_q <= ev_fire;
            num_q       <= ev_fire ? map_num : NUM_NONE;
            start_q     <= ev_fire && map_start;
            clear_q     <= ev_fire && map_clear;
            enter_q     <= ev_fire && map_enter;
            if (accept) key_code_q <= fr_code;

            if (frame_end) begin
                case (state)
                    S_IDLE: begin
                        if (fr == FR_SINGLE) begin
                            cand <= fr_code;
                            if (accept) begin
                                state      <= S_HELD;
                                key_held_q <= 1'b1;
                                cnt        <= 4'd0;
                            end else begin
                                state <= S_DEB;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    S_DEB: begin
                        if (accept) begin
                            state      <= S_HELD;
                            key_held_q <= 1'b1;
                            cnt        <= 4'd0;
                            rep_cnt    <= '0;
                            rep_first  <= 1'b0;
                        end else if (fr == FR_SINGLE && fr_code == cand) begin
                            cnt <= cnt_inc;
                        end else begin
                            state <= S_IDLE;
                            cnt   <= 4'd0;
                        end
                    end
                    S_HELD: begin
                        if (fr == FR_NONE) begin
                            rep_cnt   <= '0;
                            rep_first <= 1'b0;
                            if (DEBOUNCE == 1) begin
                                state      <= S_IDLE;
                                key_held_q <= 1'b0;
                            end else begin
                                state <= S_REL;
                                cnt   <= 4'd1;
                            end
                        end else if (rep_due) begin
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + PW'(1);
                        end
                    end
                    default: begin
                        if (fr != FR_NONE) begin
                            state <= S_HELD;
                            cnt   <= 4'd0;
                        end else if (cnt_inc == 4'(DEBOUNCE)) begin
                            state      <= S_IDLE;
                            key_held_q <= 1'b0;
                            cnt        <= 4'd0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign ev.key_valid = key_valid_q;
    assign ev.key_code  = key_code_q;
    assign ev.key_held  = key_held_q;
    assign ev.num       = num_q;
    assign ev.start     = start_q;
    assign ev.clear     = clear_q;
    assign ev.enter     = enter_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - frame-level model bench for keypad_scanner (plain and auto-repeat instances)
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SD   = 4;
    localparam int DB   = 4;
    localparam int F    = ROWS * SD;
    localparam int DLY  = 3;
    localparam int PER  = 2;

    localparam int M_IDLE = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mask;
    logic [3:0]  row0, row1, col0, col1;

    always #5 clk = ~clk;

    keypad_scanner_if #(.CW(4)) ev0 ();
    keypad_scanner_if #(.CW(4)) ev1 ();

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB),
                     .REPEAT_EN(0), .REPEAT_DLY(50), .REPEAT_PER(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .row_o(row0), .col_i(col0), .ev(ev0));

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB),
                     .REPEAT_EN(1), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut1 (
        .clk(clk), .rst_n(rst_n), .row_o(row1), .col_i(col1), .ev(ev1));

    // A pressed key shorts its row to its column.
    function automatic logic [3:0] sense(input logic [3:0] row, input logic [15:0] m);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (!row[r] && m[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    assign col0 = sense(row0, mask);
    assign col1 = sense(row1, mask);

    int total = 0;
    int bad   = 0;
    int n     = 0;
    bit started = 0;

    int st[2], cnt[2], cand[2], code[2], since[2];
    bit held[2], e_valid[2];

    int ev0_cnt, ev0_code, ev0_num, ev0_frame, fall0_frame, start0_cnt, clear0_cnt;
    int codes0[$];
    int enter1_frames[$];
    bit prev_held0;

    task automatic chk(input string name, input int m, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d actual=%0d required=%0d t=%0t", name, m, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int m = 0; m < 2; m++) begin
            st[m] = M_IDLE; cnt[m] = 0; cand[m] = 0; code[m] = 0; since[m] = 0;
            held[m] = 0; e_valid[m] = 0;
        end
    endtask

    task automatic model_frame(input int m);
        int pc, c;
        pc = $countones(mask);
        c  = 0;
        for (int i = 15; i >= 0; i--) if (mask[i]) c = i;
        case (st[m])
            M_IDLE: if (pc == 1) begin cand[m] = c; cnt[m] = 1; st[m] = M_DEB; end
            M_DEB: begin
                if (pc == 1 && c == cand[m]) begin
                    cnt[m]++;
                    if (cnt[m] == DB) begin
                        st[m] = M_HELD; held[m] = 1; code[m] = c; e_valid[m] = 1; since[m] = 0;
                    end
                end else begin
                    st[m] = M_IDLE; cnt[m] = 0;
                end
            end
            M_HELD: begin
                if (pc == 0) begin
                    st[m] = M_REL; cnt[m] = 1;
                end else begin
                    since[m]++;
                    if (m == 1 && pc == 1 &&
                        (since[m] == DLY || (since[m] > DLY && (since[m] - DLY) % PER == 0)))
                        e_valid[m] = 1;
                end
            end
            default: begin
                if (pc == 0) begin
                    cnt[m]++;
                    if (cnt[m] == DB) begin st[m] = M_IDLE; held[m] = 0; cnt[m] = 0; end
                end else begin
                    st[m] = M_HELD; since[m] = 0;
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            started = 1;
            if (!rst_n) model_reset();
            else begin
                n++;
                e_valid[0] = 0;
                e_valid[1] = 0;
                if (n % F == 0) begin
                    model_frame(0);
                    model_frame(1);
                end
            end
        end
    end

    task automatic check_dut(input int m, input logic [3:0] row, input logic v, input logic [3:0] kc,
                             input logic h, input logic [4:0] nm, input logic s, input logic c,
                             input logic e);
        int er, ev, ek, eh, en;
        if (!rst_n) begin
            er = 4'b1110; ev = 0; ek = 0; eh = 0; en = 20;
        end else begin
            er = int'(~(4'b0001 << ((n / SD) % ROWS)) & 4'hF);
            ev = int'(e_valid[m]); ek = code[m]; eh = int'(held[m]);
            en = !ev ? 20 : (ek <= 8) ? ek + 1 : (ek == 9) ? 0 : 20;
        end
        chk("row_o", m, int'(row), er);
        chk("key_valid", m, int'(v), ev);
        chk("key_code", m, int'(kc), ek);
        chk("key_held", m, int'(h), eh);
        chk("num", m, int'(nm), en);
        chk("start", m, int'(s), int'(ev != 0 && ek == 10));
        chk("clear", m, int'(c), int'(ev != 0 && ek == 11));
        chk("enter", m, int'(e), int'(ev != 0 && ek == 12));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check_dut(0, row0, ev0.key_valid, ev0.key_code, ev0.key_held, ev0.num,
                          ev0.start, ev0.clear, ev0.enter);
                check_dut(1, row1, ev1.key_valid, ev1.key_code, ev1.key_held, ev1.num,
                          ev1.start, ev1.clear, ev1.enter);
                if (rst_n) begin
                    if (ev0.key_valid) begin
                        ev0_cnt++; ev0_code = int'(ev0.key_code); ev0_num = int'(ev0.num);
                        ev0_frame = n / F; codes0.push_back(int'(ev0.key_code));
                    end
                    if (ev0.start) start0_cnt++;
                    if (ev0.clear) clear0_cnt++;
                    if (prev_held0 && !ev0.key_held) fall0_frame = n / F;
                    if (ev1.enter) enter1_frames.push_back(n / F);
                end
                prev_held0 = ev0.key_held;
            end
        end
    end

    task automatic clear_mon();
        ev0_cnt = 0; ev0_code = -1; ev0_num = -1; ev0_frame = -1; fall0_frame = -1;
        start0_cnt = 0; clear0_cnt = 0; prev_held0 = 0;
        codes0.delete(); enter1_frames.delete();
    endtask

    // Called #1 after a rising edge; releases #1 after a later rising edge so frames stay aligned.
    task automatic hold_reset(input int k);
        rst_n = 1'b0;
        mask  = '0;
        repeat (k) @(posedge clk);
        #1;
        clear_mon();
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        @(posedge clk);
        #1;
        hold_reset(3);
    endtask

    task automatic frames(input logic [15:0] m, input int k);
        repeat (k) begin
            mask = m;
            repeat (F) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_rep[5];
        exp_rep = '{4, 7, 9, 11, 13};
        rst_n = 1'b1;
        mask  = '0;
        clear_mon();
        #2 rst_n = 1'b0;

        // single press of code 5
        start_run();
        frames(16'h0020, 6);
        frames(16'h0000, 6);
        chk("press_events", 0, ev0_cnt, 1);
        chk("press_code", 0, ev0_code, 5);
        chk("press_num", 0, ev0_num, 6);
        chk("press_frame", 0, ev0_frame, 4);
        chk("release_frame", 0, fall0_frame, 10);

        // bounce on code 2
        start_run();
        for (int i = 0; i < 10; i++) frames((i % 2 == 0) ? 16'h0004 : 16'h0000, 1);
        frames(16'h0004, 6);
        frames(16'h0000, 6);
        chk("bounce_events", 0, ev0_cnt, 1);
        chk("bounce_num", 0, ev0_num, 3);
        chk("bounce_frame", 0, ev0_frame, 14);

        // chord 0+7 then release 7
        start_run();
        frames(16'h0081, 5);
        frames(16'h0001, 5);
        frames(16'h0000, 5);
        chk("chord_events", 0, ev0_cnt, 1);
        chk("chord_code", 0, ev0_code, 0);
        chk("chord_num", 0, ev0_num, 1);
        chk("chord_frame", 0, ev0_frame, 9);

        // auto-repeat on enter
        start_run();
        frames(16'h1000, 14);
        frames(16'h0000, 5);
        chk("repeat_count", 1, enter1_frames.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("repeat_frame", 1, (i < enter1_frames.size()) ? enter1_frames[i] : -1, exp_rep[i]);
        chk("norepeat_events", 0, ev0_cnt, 1);

        // start, clear, zero
        start_run();
        frames(16'h0400, 5); frames(16'h0000, 5);
        frames(16'h0800, 5); frames(16'h0000, 5);
        frames(16'h0200, 5); frames(16'h0000, 5);
        chk("seq_events", 0, ev0_cnt, 3);
        chk("seq_code0", 0, (codes0.size() > 0) ? codes0[0] : -1, 10);
        chk("seq_code1", 0, (codes0.size() > 1) ? codes0[1] : -1, 11);
        chk("seq_code2", 0, (codes0.size() > 2) ? codes0[2] : -1, 9);
        chk("seq_start", 0, start0_cnt, 1);
        chk("seq_clear", 0, clear0_cnt, 1);
        chk("seq_zero_num", 0, ev0_num, 0);

        // reset mid-debounce
        start_run();
        frames(16'h0020, 2);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_deb_row", 0, int'(row0), 4'b1110);
        chk("rst_deb_held", 0, int'(ev0.key_held), 0);
        @(posedge clk);
        #1;
        hold_reset(2);
        frames(16'h0000, 6);
        chk("rst_deb_events", 0, ev0_cnt, 0);

        // reset while held
        start_run();
        frames(16'h0008, 5);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_held_row", 0, int'(row0), 4'b1110);
        chk("rst_held_held", 0, int'(ev0.key_held), 0);
        chk("rst_held_held", 1, int'(ev1.key_held), 0);
        chk("rst_held_code", 0, int'(ev0.key_code), 0);
        @(posedge clk);
        #1;
        hold_reset(2);
        frames(16'h0000, 6);
        chk("rst_held_events", 0, ev0_cnt, 0);
        chk("rst_held_enter", 1, enter1_frames.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
